// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: writes base+addr to every word, then reads each
// word back as two bytes and reports pass/fail, error count, first failure.
module mem_pattern_tester #(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              check_only,
  input  logic [15:0]       pattern_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [15:0]       mem_wdata,
  output logic              mem_read_byte_sel,
  input  logic [7:0]        mem_rdata_byte,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       first_err_data,
  output logic              first_err_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_LO,
    S_RD_HI,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ERR_W-1:0]  E_ONE = ERR_W'(1);

  state_t              state_q;
  logic [15:0]         base_q;
  logic [7:0]          lo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cs_q;
  logic                rw_q;
  logic [15:0]         wdata_q;
  logic                sel_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [ERR_W-1:0]    err_q;
  logic [ADDR_W-1:0]   fea_q;
  logic [15:0]         fed_q;
  logic                fev_q;

  logic [ADDR_W-1:0]   addr_inc;
  logic                last;
  logic [15:0]         exp_word;
  logic [15:0]         rd_word;
  logic                mismatch;
  logic [ERR_W-1:0]    err_d;
  logic [15:0]         wdata_d;

  assign addr_inc = addr_q + A_ONE;
  assign last     = &addr_q;
  assign exp_word = base_q + 16'(addr_q);
  assign rd_word  = {mem_rdata_byte, lo_q};
  assign mismatch = (rd_word != exp_word);
  assign err_d    = (mismatch && !(&err_q)) ? err_q + E_ONE : err_q;
  assign wdata_d  = base_q + 16'(addr_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
      fev_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= pattern_base;
            err_q  <= '0;
            fea_q  <= '0;
            fed_q  <= '0;
            fev_q  <= 1'b0;
            pass_q <= 1'b0;
            addr_q <= '0;
            busy_q <= 1'b1;
            cs_q   <= 1'b1;
            sel_q  <= 1'b0;
            if (check_only) begin
              state_q <= S_RD_ADDR;
              rw_q    <= 1'b0;
            end else begin
              state_q <= S_WRITE;
              rw_q    <= 1'b1;
              wdata_q <= pattern_base;
            end
          end
        end
        S_WRITE: begin
          if (last) begin
            addr_q  <= '0;
            rw_q    <= 1'b0;
            state_q <= S_RD_ADDR;
          end else begin
            addr_q  <= addr_inc;
            wdata_q <= wdata_d;
          end
        end
        S_RD_ADDR: begin
          state_q <= S_RD_LO;
        end
        S_RD_LO: begin
          lo_q    <= mem_rdata_byte;
          sel_q   <= 1'b1;
          state_q <= S_RD_HI;
        end
        S_RD_HI: begin
          sel_q <= 1'b0;
          err_q <= err_d;
          if (mismatch && !fev_q) begin
            fea_q <= addr_q;
            fed_q <= rd_word;
            fev_q <= 1'b1;
          end
          // pass uses err_d so the last word's result is included
          if (last) begin
            cs_q    <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_inc;
            state_q <= S_RD_ADDR;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr          = addr_q;
  assign mem_cs            = cs_q;
  assign mem_rw            = rw_q;
  assign mem_wdata         = wdata_q;
  assign mem_read_byte_sel = sel_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_count         = err_q;
  assign first_err_addr    = fea_q;
  assign first_err_data    = fed_q;
  assign first_err_valid   = fev_q;

endmodule
